// File: rtl/demux_stream_n.sv
// 1-to-N stream demultiplexer with one registered holding slot per output channel.
// Words are routed by in_sel (directed mode) or by a rotating pointer (round-robin mode).
module demux_stream_n #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_OUT    = 4,
  parameter int unsigned SEL_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          mode,
  input  logic [SEL_W-1:0]              in_sel,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic [NUM_OUT-1:0]            out_valid,
  input  logic [NUM_OUT-1:0]            out_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_data,
  output logic [SEL_W-1:0]              rr_ptr,
  output logic                          frame_done,
  output logic                          err_sel
);

  localparam int unsigned SEL_SPAN = 2 ** SEL_W;

  logic [SEL_W-1:0]      tgt;
  logic                  tgt_ok;
  logic [NUM_OUT-1:0]    tgt_hot;
  logic [NUM_OUT-1:0]    fill;
  logic [NUM_OUT-1:0]    drain;
  logic [NUM_OUT-1:0]    valid_nxt;
  logic                  accept;
  logic                  rr_last;
  logic [SEL_W-1:0]      rr_nxt;
  logic [DATA_WIDTH-1:0] slot_q [NUM_OUT];

  // Target selection: explicit channel or the round-robin pointer
  always_comb begin
    tgt = mode ? rr_ptr : in_sel;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      tgt_hot[k] = (tgt == SEL_W'(k));
    end
  end

  // Out-of-range targets only exist when the select space exceeds the channel count
  generate
    if (NUM_OUT < SEL_SPAN) begin : g_range_chk
      assign tgt_ok = (32'(tgt) < NUM_OUT);
    end else begin : g_range_full
      assign tgt_ok = 1'b1;
    end
  endgenerate

  // Handshake, per-channel fill/drain and next round-robin pointer
  always_comb begin
    in_ready  = !clear && (!tgt_ok || (|(tgt_hot & (~out_valid | out_ready))));
    accept    = in_valid && in_ready;
    fill      = accept ? tgt_hot : '0;
    drain     = out_valid & out_ready;
    valid_nxt = (out_valid & ~drain) | fill;
    rr_last   = (rr_ptr == SEL_W'(NUM_OUT - 1));
    rr_nxt    = rr_last ? '0 : rr_ptr + SEL_W'(1);
  end

  // Control state: slot valids, pointer, frame pulse and sticky select error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= '0;
      rr_ptr     <= '0;
      frame_done <= 1'b0;
      err_sel    <= 1'b0;
    end else if (clear) begin
      out_valid  <= '0;
      rr_ptr     <= '0;
      frame_done <= 1'b0;
      err_sel    <= 1'b0;
    end else begin
      out_valid  <= valid_nxt;
      frame_done <= accept && mode && rr_last;
      if (accept && mode) begin
        rr_ptr <= rr_nxt;
      end
      if (accept && !tgt_ok) begin
        err_sel <= 1'b1;
      end
    end
  end

  // Slot data: loads on fill, survives drain and clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (fill[k]) begin
          slot_q[k] <= in_data;
        end
      end
    end
  end

  // Flatten slots onto the output bus
  generate
    for (genvar g = 0; g < NUM_OUT; g++) begin : g_flat
      assign out_data[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: directed scenarios plus random traffic against a behavioural model.
module tb_demux_stream_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        mode;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [127:0] out_data;
  logic [1:0]  rr_ptr;
  logic        frame_done;
  logic        err_sel;

  // Second instance with a sparse select space (3 channels, 2-bit select)
  logic        clear_b;
  logic [1:0]  in_sel_b;
  logic        in_valid_b;
  logic        in_ready_b;
  logic [31:0] in_data_b;
  logic [2:0]  out_valid_b;
  logic [2:0]  out_ready_b;
  logic [95:0] out_data_b;
  logic [1:0]  rr_ptr_b;
  logic        frame_done_b;
  logic        err_sel_b;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit          m_valid [4];
  logic [31:0] m_data  [4];
  int          m_rr;
  bit          m_fd;
  bit          m_err;

  always #5 clk = ~clk;

  demux_stream_n #(.DATA_WIDTH(32), .NUM_OUT(4), .SEL_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode(mode), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rr_ptr(rr_ptr), .frame_done(frame_done), .err_sel(err_sel)
  );

  demux_stream_n #(.DATA_WIDTH(32), .NUM_OUT(3), .SEL_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b), .mode(1'b0), .in_sel(in_sel_b),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .rr_ptr(rr_ptr_b), .frame_done(frame_done_b), .err_sel(err_sel_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    m_rr  = 0;
    m_fd  = 1'b0;
    m_err = 1'b0;
  endtask

  // Compare every registered output of the 4-channel instance with the model
  task automatic check_outputs(input string tag);
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = m_valid[k];
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s.out_data%0d", tag, k), 64'(out_data[k*32 +: 32]), 64'(m_data[k]));
    end
    chk({tag, ".rr_ptr"}, 64'(rr_ptr), 64'(m_rr));
    chk({tag, ".frame_done"}, 64'(frame_done), 64'(m_fd));
    chk({tag, ".err_sel"}, 64'(err_sel), 64'(m_err));
  endtask

  // One clock cycle on the 4-channel instance: drive, check ready, clock, check outputs
  task automatic step(input string tag, input bit clr, input bit md, input logic [1:0] sel,
                      input bit vld, input logic [31:0] d, input logic [3:0] ordy);
    int  t;
    bit  exp_rdy;
    bit  acc;
    clear = clr; mode = md; in_sel = sel; in_valid = vld; in_data = d; out_ready = ordy;
    #1;
    t = md ? m_rr : int'(sel);
    exp_rdy = !clr && (!m_valid[t] || ordy[t]);
    acc = vld && exp_rdy;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
    if (clr) begin
      for (int k = 0; k < 4; k++) m_valid[k] = 1'b0;
      m_rr = 0; m_fd = 1'b0; m_err = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) if (m_valid[k] && ordy[k]) m_valid[k] = 1'b0;
      m_fd = acc && md && (m_rr == 3);
      if (acc) begin
        m_valid[t] = 1'b1;
        m_data[t]  = d;
        if (md) m_rr = (m_rr + 1) % 4;
      end
    end
    check_outputs(tag);
  endtask

  initial begin
    int fd_count;
    rst_n = 1'b0; clear = 1'b0; mode = 1'b0; in_sel = '0; in_valid = 1'b0;
    in_data = '0; out_ready = '0;
    clear_b = 1'b0; in_sel_b = '0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_reset");

    // Out-of-range select on the 3-channel instance
    in_sel_b = 2'd3; in_data_b = 32'hDEAD; in_valid_b = 1'b1; out_ready_b = 3'b111;
    #1;
    chk("oor.in_ready", 64'(in_ready_b), 64'd1);
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    chk("oor.out_valid", 64'(out_valid_b), 64'd0);
    chk("oor.err_sel", 64'(err_sel_b), 64'd1);
    chk("oor.out_data", 64'(out_data_b), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("oor.err_sticky", 64'(err_sel_b), 64'd1);
    in_sel_b = 2'd1; in_data_b = 32'h1234; in_valid_b = 1'b1;
    @(posedge clk);
    #1;
    in_valid_b = 1'b0;
    chk("oor.in_range_valid", 64'(out_valid_b), 64'b010);
    chk("oor.in_range_data", 64'(out_data_b[63:32]), 64'h1234);
    chk("oor.err_still", 64'(err_sel_b), 64'd1);
    clear_b = 1'b1;
    @(posedge clk);
    #1;
    clear_b = 1'b0;
    chk("oor.err_cleared", 64'(err_sel_b), 64'd0);
    chk("oor.clear_valid", 64'(out_valid_b), 64'd0);

    // Directed routing, back-to-back
    for (int k = 0; k < 4; k++) begin
      step($sformatf("dir%0d", k), 1'b0, 1'b0, 2'(k), 1'b1, 32'hA0 + 32'(k), 4'b1111);
      chk($sformatf("dir%0d.word", k), 64'(out_data[k*32 +: 32]), 64'hA0 + 64'(k));
    end
    step("dir_idle", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 4'b1111);

    // Round-robin distribution and frame pulses
    fd_count = 0;
    for (int i = 0; i < 8; i++) begin
      step($sformatf("rr%0d", i), 1'b0, 1'b1, 2'd0, 1'b1, 32'h10 + 32'(i), 4'b1111);
      chk($sformatf("rr%0d.chan", i), 64'(out_valid), 64'(4'b0001 << (i % 4)));
      if (frame_done) fd_count++;
    end
    chk("rr.frame_count", 64'(fd_count), 64'd2);
    chk("rr.ptr_end", 64'(rr_ptr), 64'd0);
    step("rr_idle", 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 4'b1111);

    // Backpressure on channel 2
    step("bp0", 1'b0, 1'b0, 2'd2, 1'b1, 32'h55, 4'b1011);
    step("bp1", 1'b0, 1'b0, 2'd2, 1'b1, 32'h66, 4'b1011);
    chk("bp1.blocked", 64'(in_ready), 64'd0);
    step("bp2", 1'b0, 1'b0, 2'd1, 1'b1, 32'h77, 4'b1001);
    step("bp3", 1'b0, 1'b0, 2'd2, 1'b1, 32'h66, 4'b1111);
    chk("bp3.replaced", 64'(out_data[95:64]), 64'h66);
    step("bp_idle", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 4'b1111);

    // Clear priority: ch0/ch1 full with pointer at 2
    step("cl0", 1'b0, 1'b1, 2'd0, 1'b1, 32'hC0, 4'b0000);
    step("cl1", 1'b0, 1'b1, 2'd0, 1'b1, 32'hC1, 4'b0000);
    chk("cl1.ptr", 64'(rr_ptr), 64'd2);
    step("cl2", 1'b1, 1'b1, 2'd0, 1'b1, 32'hC2, 4'b0000);
    chk("cl2.ptr", 64'(rr_ptr), 64'd0);
    chk("cl2.valid", 64'(out_valid), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($sformatf("rnd%0d", i), ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), $urandom(),
           4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-stream
    step("ar0", 1'b0, 1'b1, 2'd0, 1'b1, 32'hBEEF, 4'b0000);
    step("ar1", 1'b0, 1'b0, 2'd3, 1'b1, 32'hCAFE, 4'b0000);
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    step("ar_idle", 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 4'b1111);
    step("ar_resume", 1'b0, 1'b1, 2'd0, 1'b1, 32'h99, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
